// File: rtl/uart_pkt_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkt_pkg
// Shared definitions for the UART pixel-packet decoder.
//
// A packet is three UART bytes, MSB byte first:
//   {PKT_HEADER[2:0], loc[9:0], data[7:0], footer[2:0]}
//
// Contents:
//   PKT_HEADER            fixed 3-bit header pattern in the first byte
//   LOC_W / DATA_W / FTR_W field widths
//   S_B0..S_CHK           decoder FSM state encoding
//   calc_footer()         footer check bits for a (data, loc) pair
// ---------------------------------------------------------------------------
package uart_pkt_pkg;

  localparam logic [2:0] PKT_HEADER = 3'b101;

  localparam int LOC_W  = 10;
  localparam int DATA_W = 8;
  localparam int FTR_W  = 3;

  typedef logic [1:0] state_t;

  // S_B0: waiting for a header byte
  // S_B1: waiting for the middle byte
  // S_B2: waiting for the last byte
  // S_CHK: one-cycle evaluation of the assembled packet
  localparam state_t S_B0  = 2'd0;
  localparam state_t S_B1  = 2'd1;
  localparam state_t S_B2  = 2'd2;
  localparam state_t S_CHK = 2'd3;

  // Footer bits:
  //   [2] parity of the data byte
  //   [1] parity of the location
  //   [0] parity of the data high nibble together with the location high half
  function automatic logic [FTR_W-1:0] calc_footer(
    input logic [DATA_W-1:0] data,
    input logic [LOC_W-1:0]  loc
  );
    calc_footer = {^data, ^loc, ^{data[7:4], loc[9:5]}};
  endfunction

endpackage

// File: rtl/pkt_footer_check.sv
// ---------------------------------------------------------------------------
// pkt_footer_check
// Purely combinational comparison of a received footer against the footer
// recomputed from the received location and data fields.
//
// Ports:
//   loc_i        received 10-bit location
//   data_i       received 8-bit pixel data
//   footer_i     received 3-bit footer
//   footer_ok_o  high when footer_i matches the recomputed footer
// ---------------------------------------------------------------------------
module pkt_footer_check
  import uart_pkt_pkg::*;
(
  input  logic [LOC_W-1:0]  loc_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [FTR_W-1:0]  footer_i,
  output logic              footer_ok_o
);

  logic [FTR_W-1:0] expected;

  assign expected    = calc_footer(data_i, loc_i);
  assign footer_ok_o = (expected == footer_i);

endmodule

// File: rtl/uart_packet_decoder.sv
// ---------------------------------------------------------------------------
// uart_packet_decoder
// Assembles three UART bytes into a pixel packet, validates header, footer
// and location range, and writes accepted pixels into the pixel RAM. Counts
// accepted packets and raises receive_done once NUM_PIXELS have arrived.
//
// Ports:
//   clk            system clock
//   rst            asynchronous active-low reset
//   rx_data        byte from the UART receiver
//   rx_valid       one-cycle strobe qualifying rx_data
//   done_clr       synchronous clear of counters/receive_done, restarts reception
//   mem_we         pixel RAM write strobe (one cycle)
//   mem_addr       pixel RAM address (zero-extended loc), held between writes
//   mem_wdata      pixel data, held between writes
//   count_packets  accepted packet count (saturating)
//   receive_done   sticky, set once count_packets reaches NUM_PIXELS
//   err_header     bytes dropped for a bad header
//   err_footer     packets dropped for a footer mismatch
//   err_range      packets dropped for loc >= NUM_PIXELS
//   err_timeout    partial packets discarded after an inter-byte timeout
// ---------------------------------------------------------------------------
module uart_packet_decoder
  import uart_pkt_pkg::*;
#(
  parameter int NUM_PIXELS     = 20,
  parameter int ADDR_W         = 10,
  parameter int TIMEOUT_CYCLES = 4000,
  parameter int ERR_W          = 16
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              done_clr,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic [31:0]       count_packets,
  output logic              receive_done,
  output logic [ERR_W-1:0]  err_header,
  output logic [ERR_W-1:0]  err_footer,
  output logic [ERR_W-1:0]  err_range,
  output logic [ERR_W-1:0]  err_timeout
);

  if (NUM_PIXELS < 1 || NUM_PIXELS > 1024) begin : g_bad_num_pixels
    $error("uart_packet_decoder: NUM_PIXELS must be 1..1024");
  end
  if (ADDR_W < LOC_W) begin : g_bad_addr_w
    $error("uart_packet_decoder: ADDR_W must be at least 10");
  end

  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LIMIT  = IDLE_W'(TIMEOUT_CYCLES);
  // One extra bit so NUM_PIXELS=1024 is representable for the range compare.
  localparam logic [LOC_W:0]    NUM_PIX_EXT = (LOC_W + 1)'(NUM_PIXELS);

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    sat_inc = (&v) ? v : v + 1'b1;
  endfunction

  state_t              state_q, state_d;
  state_t              eff_state;
  logic [LOC_W-1:0]    loc_q, loc_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [FTR_W-1:0]    ftr_q, ftr_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic [31:0]         count_q, count_d;
  logic                done_q, done_d;
  logic [ERR_W-1:0]    err_header_q, err_header_d;
  logic [ERR_W-1:0]    err_footer_q, err_footer_d;
  logic [ERR_W-1:0]    err_range_q, err_range_d;
  logic [ERR_W-1:0]    err_timeout_q, err_timeout_d;
  logic [ADDR_W-1:0]   addr_hold_q, addr_hold_d;
  logic [7:0]          wdata_hold_q, wdata_hold_d;

  logic footer_ok;
  logic in_range;
  logic timeout_hit;
  logic write_ok;

  pkt_footer_check u_footer_check (
    .loc_i       (loc_q),
    .data_i      (data_q),
    .footer_i    (ftr_q),
    .footer_ok_o (footer_ok)
  );

  assign in_range    = ({1'b0, loc_q} < NUM_PIX_EXT);
  assign timeout_hit = ((state_q == S_B1) || (state_q == S_B2)) && (idle_q == IDLE_LIMIT);

  always_comb begin
    state_d       = state_q;
    eff_state     = state_q;
    loc_d         = loc_q;
    data_d        = data_q;
    ftr_d         = ftr_q;
    idle_d        = '0;
    count_d       = count_q;
    done_d        = done_q;
    err_header_d  = err_header_q;
    err_footer_d  = err_footer_q;
    err_range_d   = err_range_q;
    err_timeout_d = err_timeout_q;
    addr_hold_d   = addr_hold_q;
    wdata_hold_d  = wdata_hold_q;
    write_ok      = 1'b0;

    if (done_clr) begin
      // Any byte or pending packet in this cycle is dropped.
      state_d       = S_B0;
      count_d       = '0;
      done_d        = 1'b0;
      err_header_d  = '0;
      err_footer_d  = '0;
      err_range_d   = '0;
      err_timeout_d = '0;
    end else begin
      // On timeout the partial packet is abandoned and a byte arriving in the
      // same cycle is decoded as if we were already back in S_B0.
      if (timeout_hit) begin
        eff_state     = S_B0;
        state_d       = S_B0;
        err_timeout_d = sat_inc(err_timeout_q);
      end

      case (eff_state)
        S_B0: begin
          if (rx_valid) begin
            if (rx_data[7:5] == PKT_HEADER) begin
              loc_d[9:5] = rx_data[4:0];
              state_d    = S_B1;
            end else begin
              err_header_d = sat_inc(err_header_q);
            end
          end
        end
        S_B1: begin
          if (rx_valid) begin
            loc_d[4:0]  = rx_data[7:3];
            data_d[7:5] = rx_data[2:0];
            state_d     = S_B2;
          end else begin
            idle_d = idle_q + 1'b1;
          end
        end
        S_B2: begin
          if (rx_valid) begin
            data_d[4:0] = rx_data[7:3];
            ftr_d       = rx_data[2:0];
            state_d     = S_CHK;
          end else begin
            idle_d = idle_q + 1'b1;
          end
        end
        S_CHK: begin
          state_d = S_B0;
          if (!footer_ok) begin
            err_footer_d = sat_inc(err_footer_q);
          end else if (!in_range) begin
            err_range_d = sat_inc(err_range_q);
          end else begin
            write_ok     = 1'b1;
            addr_hold_d  = ADDR_W'(loc_q);
            wdata_hold_d = data_q;
            if (count_q != '1) begin
              count_d = count_q + 1'b1;
            end
          end
        end
        default: state_d = S_B0;
      endcase

      if (count_d >= 32'(NUM_PIXELS)) begin
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_B0;
      loc_q         <= '0;
      data_q        <= '0;
      ftr_q         <= '0;
      idle_q        <= '0;
      count_q       <= '0;
      done_q        <= 1'b0;
      err_header_q  <= '0;
      err_footer_q  <= '0;
      err_range_q   <= '0;
      err_timeout_q <= '0;
      addr_hold_q   <= '0;
      wdata_hold_q  <= '0;
    end else begin
      state_q       <= state_d;
      loc_q         <= loc_d;
      data_q        <= data_d;
      ftr_q         <= ftr_d;
      idle_q        <= idle_d;
      count_q       <= count_d;
      done_q        <= done_d;
      err_header_q  <= err_header_d;
      err_footer_q  <= err_footer_d;
      err_range_q   <= err_range_d;
      err_timeout_q <= err_timeout_d;
      addr_hold_q   <= addr_hold_d;
      wdata_hold_q  <= wdata_hold_d;
    end
  end

  // The write strobe comes straight from the S_CHK decision so the pulse
  // lands one cycle after the last byte; address/data follow the same mux and
  // otherwise show the last written values.
  assign mem_we        = write_ok;
  assign mem_addr      = write_ok ? addr_hold_d : addr_hold_q;
  assign mem_wdata     = write_ok ? wdata_hold_d : wdata_hold_q;
  assign count_packets = count_q;
  assign receive_done  = done_q;
  assign err_header    = err_header_q;
  assign err_footer    = err_footer_q;
  assign err_range     = err_range_q;
  assign err_timeout   = err_timeout_q;

endmodule

// File: tb/tb_uart_packet_decoder.sv
module tb_uart_packet_decoder;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        done_clr;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [31:0] count_packets;
  logic        receive_done;
  logic [15:0] err_header;
  logic [15:0] err_footer;
  logic [15:0] err_range;
  logic [15:0] err_timeout;

  int total;
  int bad;
  int we_cnt;
  logic [9:0] mon_addr;
  logic [7:0] mon_data;

  uart_packet_decoder #(
    .NUM_PIXELS     (20),
    .ADDR_W         (10),
    .TIMEOUT_CYCLES (4000),
    .ERR_W          (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .done_clr      (done_clr),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .count_packets (count_packets),
    .receive_done  (receive_done),
    .err_header    (err_header),
    .err_footer    (err_footer),
    .err_range     (err_range),
    .err_timeout   (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write observer: counts RAM write pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      we_cnt   = we_cnt + 1;
      mon_addr = mem_addr;
      mon_data = mem_wdata;
    end
  end

  function automatic logic [2:0] tb_ftr(input logic [9:0] l, input logic [7:0] d);
    return {^d, ^l, ^{d[7:4], l[9:5]}};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    $display("rx byte %02h", b);
  endtask

  // Leaves time in the S_CHK cycle (one cycle after the last byte).
  task automatic send_pkt(input logic [9:0] l, input logic [7:0] d, input logic [2:0] fx);
    logic [23:0] p;
    p = {3'b101, l, d, tb_ftr(l, d) ^ fx};
    $display("packet loc=%0d data=%02h ftr_xor=%0d", l, d, fx);
    send_byte(p[23:16]);
    step(2);
    send_byte(p[15:8]);
    step(2);
    send_byte(p[7:0]);
  endtask

  task automatic clear_counters();
    done_clr = 1'b1;
    step(1);
    done_clr = 1'b0;
    step(1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we: got %0h want 0", mem_we); end
    total++; if (count_packets !== 32'd0) begin bad++; $display("FAIL reset_count: got %0h want 0", count_packets); end
    total++; if (receive_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %0h want 0", receive_done); end
    total++; if ({err_header, err_footer, err_range, err_timeout} !== 64'd0) begin
      bad++; $display("FAIL reset_errs: got %0h want 0", {err_header, err_footer, err_range, err_timeout});
    end
    #9 rst = 1'b1;
    step(1);
  endtask

  task automatic test_single_packet();
    int base;
    base = we_cnt;
    send_byte(8'hA0); step(2);
    send_byte(8'h1A); step(2);
    send_byte(8'hD0);
    total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL single_we: got %0h want 1", mem_we); end
    total++; if (mem_addr !== 10'd3) begin bad++; $display("FAIL single_addr: got %0h want 3", mem_addr); end
    total++; if (mem_wdata !== 8'h5A) begin bad++; $display("FAIL single_wdata: got %0h want 5a", mem_wdata); end
    total++; if (count_packets !== 32'd0) begin bad++; $display("FAIL single_count_early: got %0h want 0", count_packets); end
    step(1);
    total++; if (count_packets !== 32'd1) begin bad++; $display("FAIL single_count: got %0h want 1", count_packets); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL single_we_low: got %0h want 0", mem_we); end
    total++; if (mem_addr !== 10'd3) begin bad++; $display("FAIL single_addr_hold: got %0h want 3", mem_addr); end
    total++; if (we_cnt - base !== 1) begin bad++; $display("FAIL single_pulses: got %0d want 1", we_cnt - base); end
  endtask

  task automatic test_bad_footer();
    int base;
    clear_counters();
    base = we_cnt;
    send_byte(8'hA0); step(2);
    send_byte(8'h1A); step(2);
    send_byte(8'hD1); step(2);
    total++; if (we_cnt !== base) begin bad++; $display("FAIL footer_no_write: got %0d want %0d", we_cnt, base); end
    total++; if (err_footer !== 16'd1) begin bad++; $display("FAIL footer_err: got %0h want 1", err_footer); end
    total++; if (count_packets !== 32'd0) begin bad++; $display("FAIL footer_count: got %0h want 0", count_packets); end
    send_pkt(10'd3, 8'h5A, 3'd0); step(1);
    total++; if (count_packets !== 32'd1) begin bad++; $display("FAIL footer_next_count: got %0h want 1", count_packets); end
    total++; if (we_cnt !== base + 1) begin bad++; $display("FAIL footer_next_write: got %0d want %0d", we_cnt, base + 1); end
  endtask

  task automatic test_bad_header();
    clear_counters();
    send_byte(8'h00); step(2);
    total++; if (err_header !== 16'd1) begin bad++; $display("FAIL header_err: got %0h want 1", err_header); end
    send_pkt(10'd7, 8'hC3, 3'd0); step(1);
    total++; if (count_packets !== 32'd1) begin bad++; $display("FAIL header_count: got %0h want 1", count_packets); end
    total++; if (mon_addr !== 10'd7) begin bad++; $display("FAIL header_addr: got %0h want 7", mon_addr); end
    total++; if (mon_data !== 8'hC3) begin bad++; $display("FAIL header_data: got %0h want c3", mon_data); end
  endtask

  task automatic test_timeout();
    clear_counters();
    send_byte(8'hA0); step(2);
    send_byte(8'h1A);
    step(5000);
    total++; if (err_timeout !== 16'd1) begin bad++; $display("FAIL timeout_err: got %0h want 1", err_timeout); end
    total++; if (count_packets !== 32'd0) begin bad++; $display("FAIL timeout_count0: got %0h want 0", count_packets); end
    send_pkt(10'd5, 8'h11, 3'd0); step(1);
    total++; if (count_packets !== 32'd1) begin bad++; $display("FAIL timeout_count: got %0h want 1", count_packets); end
    total++; if ({err_header, err_footer} !== 32'd0) begin
      bad++; $display("FAIL timeout_other_errs: got %0h want 0", {err_header, err_footer});
    end
    total++; if (mon_addr !== 10'd5) begin bad++; $display("FAIL timeout_addr: got %0h want 5", mon_addr); end
  endtask

  task automatic test_fill_and_range();
    int base;
    clear_counters();
    base = we_cnt;
    for (int i = 0; i < 20; i++) begin
      send_pkt(10'(i), 8'(i * 7 + 1), 3'd0); step(1);
      total++; if (count_packets !== 32'(i + 1)) begin
        bad++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, count_packets, i + 1);
      end
      total++; if (receive_done !== (i == 19)) begin
        bad++; $display("FAIL fill_done[%0d]: got %0h want %0h", i, receive_done, (i == 19));
      end
      total++; if (mon_data !== 8'(i * 7 + 1)) begin
        bad++; $display("FAIL fill_data[%0d]: got %0h want %0h", i, mon_data, 8'(i * 7 + 1));
      end
    end
    send_pkt(10'd25, 8'h99, 3'd0); step(2);
    total++; if (err_range !== 16'd1) begin bad++; $display("FAIL range_err: got %0h want 1", err_range); end
    total++; if (we_cnt - base !== 20) begin bad++; $display("FAIL range_writes: got %0d want 20", we_cnt - base); end
    total++; if (count_packets !== 32'd20) begin bad++; $display("FAIL range_count: got %0d want 20", count_packets); end
    send_pkt(10'd2, 8'h44, 3'd0); step(1);
    total++; if (count_packets !== 32'd21) begin bad++; $display("FAIL extra_count: got %0d want 21", count_packets); end
    total++; if (receive_done !== 1'b1) begin bad++; $display("FAIL extra_done: got %0h want 1", receive_done); end
    total++; if (mon_addr !== 10'd2) begin bad++; $display("FAIL extra_addr: got %0h want 2", mon_addr); end
  endtask

  task automatic test_done_clr();
    int base;
    clear_counters();
    total++; if (count_packets !== 32'd0) begin bad++; $display("FAIL clr_count: got %0d want 0", count_packets); end
    total++; if (receive_done !== 1'b0) begin bad++; $display("FAIL clr_done: got %0h want 0", receive_done); end
    total++; if (err_range !== 16'd0) begin bad++; $display("FAIL clr_range: got %0h want 0", err_range); end
    // Header byte coincident with done_clr is dropped; the rest then fail headers.
    base = we_cnt;
    done_clr = 1'b1; rx_data = 8'hA0; rx_valid = 1'b1;
    step(1);
    done_clr = 1'b0; rx_valid = 1'b0;
    step(2);
    send_byte(8'h1A); step(2);
    send_byte(8'hD0); step(2);
    total++; if (err_header !== 16'd2) begin bad++; $display("FAIL clr_drop_hdr: got %0h want 2", err_header); end
    total++; if (we_cnt !== base) begin bad++; $display("FAIL clr_drop_write: got %0d want %0d", we_cnt, base); end
    // done_clr during the check cycle suppresses the write.
    send_pkt(10'd4, 8'h21, 3'd0);
    done_clr = 1'b1;
    #1;
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL clr_chk_we: got %0h want 0", mem_we); end
    step(1);
    done_clr = 1'b0;
    step(1);
    total++; if (count_packets !== 32'd0) begin bad++; $display("FAIL clr_chk_count: got %0d want 0", count_packets); end
    total++; if (err_header !== 16'd0) begin bad++; $display("FAIL clr_chk_hdr: got %0h want 0", err_header); end
    total++; if (we_cnt !== base) begin bad++; $display("FAIL clr_chk_write: got %0d want %0d", we_cnt, base); end
  endtask

  task automatic test_reset_midpacket();
    send_pkt(10'd1, 8'h0F, 3'd0); step(1);
    send_byte(8'hA0); step(2);
    send_byte(8'h1A);
    #2 rst = 1'b0;
    #2;
    total++; if (count_packets !== 32'd0) begin bad++; $display("FAIL rstmid_count: got %0d want 0", count_packets); end
    step(2);
    rst = 1'b1;
    step(1);
    send_pkt(10'd9, 8'h80, 3'd0); step(1);
    total++; if (count_packets !== 32'd1) begin bad++; $display("FAIL rstmid_pkt: got %0d want 1", count_packets); end
    total++; if ({err_header, err_footer, err_range, err_timeout} !== 64'd0) begin
      bad++; $display("FAIL rstmid_errs: got %0h want 0", {err_header, err_footer, err_range, err_timeout});
    end
    total++; if (mon_addr !== 10'd9 || mon_data !== 8'h80) begin
      bad++; $display("FAIL rstmid_write: got %0h/%0h want 9/80", mon_addr, mon_data);
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    we_cnt   = 0;
    mon_addr = '0;
    mon_data = '0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    done_clr = 1'b0;
    test_reset();
    test_single_packet();
    test_bad_footer();
    test_bad_header();
    test_timeout();
    test_fill_and_range();
    test_done_clr();
    test_reset_midpacket();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
